csr_counter_bank: RTL and testbench

CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

---
 rtl/csr_counter_bank_pkg.sv | 43 ++++
 rtl/csr_counter_bank_if.sv | 24 ++
 rtl/csr_counter_bank_counter.sv | 35 +++
 rtl/csr_counter_bank.sv | 122 ++++++++++++
 tb/tb_csr_counter_bank.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_counter_bank_pkg.sv
// Shared definitions for the performance-counter CSR bank: address map, op encoding, offset helpers.
package csr_cnt_pkg;

    localparam logic [11:0] CSR_CNT_RO_LO = 12'hC00;
    localparam logic [11:0] CSR_CNT_RO_HI = 12'hC80;
    localparam logic [11:0] CSR_CNT_RW_LO = 12'hB00;
    localparam logic [11:0] CSR_CNT_RW_HI = 12'hB80;
    localparam logic [11:0] CSR_INHIBIT   = 12'h320;
    localparam logic [11:0] CSR_OVF_STAT  = 12'h7C0;
    localparam logic [11:0] CSR_OVF_MASK  = 12'h7C1;

    typedef enum logic [1:0] {
        CSR_OP_READ  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    // Offset 1 is skipped so cycle/instret land on their architectural slots.
    function automatic logic [4:0] cnt_off(input int k);
        if (k == 0)      return 5'd0;
        else if (k == 1) return 5'd2;
        else             return 5'(k + 1);
    endfunction

    function automatic logic [31:0] cnt_bit_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[cnt_off(k)] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] csr_modify(input csr_op_e op, input logic [31:0] old,
                                               input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old | wdata;
            CSR_OP_CLEAR: return old & ~wdata;
            default:      return old;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// CSR access bus into the counter bank; response is combinational in the same cycle.
interface csr_counter_bank_if #(
    parameter int DATA_WIDTH = 32
);
    import csr_cnt_pkg::*;

    logic [11:0]           csr_addr_i;
    csr_op_e               csr_op_i;
    logic [DATA_WIDTH-1:0] csr_wdata_i;
    logic [DATA_WIDTH-1:0] csr_rdata_o;
    logic                  csr_hit_o;
    logic                  csr_illegal_o;

    modport master (
        output csr_addr_i, csr_op_i, csr_wdata_i,
        input  csr_rdata_o, csr_hit_o, csr_illegal_o
    );

    modport slave (
        input  csr_addr_i, csr_op_i, csr_wdata_i,
        output csr_rdata_o, csr_hit_o, csr_illegal_o
    );

endinterface

// File: rtl/csr_counter_bank_counter.sv
// One counter: half-word CSR writes override the increment; wrap_o flags an all-ones increment.
module csr_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 wrap_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0] = wdata_i;
            if (wr_hi_i) cnt_d[CNT_WIDTH-1:32] = wdata_i[CNT_WIDTH-33:0];
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = inc_i && !wr_lo_i && !wr_hi_i && (&cnt_q);

endmodule

// File: rtl/csr_counter_bank.sv
// Bank of NUM_CNT performance counters (cycle, instret, hpm events) with CSR access,
// per-counter inhibit, and sticky overflow status driving a maskable interrupt.
module csr_counter_bank
    import csr_cnt_pkg::*;
#(
    parameter int NUM_CNT    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               retire_i,
    input  logic [NUM_CNT-1:0] event_i,
    csr_counter_bank_if.slave  csr,
    output logic               ovf_irq_o
);

    localparam logic [31:0] VALID = cnt_bit_mask(NUM_CNT);

    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_CNT-1:0][63:0]          cnt_ext;
    logic [NUM_CNT-1:0]                inc, wr_lo, wr_hi, wrap;
    logic [31:0]                       inhibit_q, inhibit_d, ovf_q, ovf_d, mask_q, mask_d;
    logic [DATA_WIDTH-1:0]             rdata, wr_val;
    logic [11:0]                       addr;
    csr_op_e                           op;
    logic                              is_wr, hit, ro_hit;
    logic                              unused_evt;

    assign addr       = csr.csr_addr_i;
    assign op         = csr.csr_op_i;
    assign is_wr      = (op != CSR_OP_READ);
    assign unused_evt = ^event_i[1:0];

    always_comb begin
        rdata  = '0;
        hit    = 1'b0;
        ro_hit = 1'b0;
        wr_lo  = '0;
        wr_hi  = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (addr == CSR_CNT_RO_LO + 12'(cnt_off(k))) begin
                hit = 1'b1; ro_hit = 1'b1; rdata = cnt_ext[k][31:0];
            end
            if (addr == CSR_CNT_RO_HI + 12'(cnt_off(k))) begin
                hit = 1'b1; ro_hit = 1'b1; rdata = cnt_ext[k][63:32];
            end
            if (addr == CSR_CNT_RW_LO + 12'(cnt_off(k))) begin
                hit = 1'b1; rdata = cnt_ext[k][31:0]; wr_lo[k] = is_wr;
            end
            if (addr == CSR_CNT_RW_HI + 12'(cnt_off(k))) begin
                hit = 1'b1; rdata = cnt_ext[k][63:32]; wr_hi[k] = is_wr;
            end
        end
        case (addr)
            CSR_INHIBIT:  begin hit = 1'b1; rdata = inhibit_q; end
            CSR_OVF_STAT: begin hit = 1'b1; rdata = ovf_q;     end
            CSR_OVF_MASK: begin hit = 1'b1; rdata = mask_q;    end
            default: ;
        endcase
    end

    // The read mux already selects the addressed half, so it doubles as the RMW source.
    assign wr_val = csr_modify(op, rdata, csr.csr_wdata_i);

    assign csr.csr_rdata_o   = rdata;
    assign csr.csr_hit_o     = hit;
    assign csr.csr_illegal_o = ro_hit & is_wr;

    always_comb begin
        inhibit_d = inhibit_q;
        ovf_d     = ovf_q;
        mask_d    = mask_q;
        if (is_wr && addr == CSR_INHIBIT)  inhibit_d = wr_val & VALID;
        if (is_wr && addr == CSR_OVF_MASK) mask_d    = wr_val & VALID;
        if (addr == CSR_OVF_STAT && (op == CSR_OP_WRITE || op == CSR_OP_SET))
            ovf_d = ovf_q & ~csr.csr_wdata_i;
        // Applied after the clear so a coincident wrap keeps its bit.
        for (int k = 0; k < NUM_CNT; k++)
            if (wrap[k]) ovf_d[cnt_off(k)] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inhibit_q <= '0;
            ovf_q     <= '0;
            mask_q    <= '0;
        end else begin
            inhibit_q <= inhibit_d;
            ovf_q     <= ovf_d;
            mask_q    <= mask_d;
        end
    end

    assign ovf_irq_o = |(ovf_q & mask_q);

    for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
        localparam logic [4:0] OFF = cnt_off(k);
        logic src;
        if (k == 0) begin : g_cyc
            assign src = 1'b1;
        end else if (k == 1) begin : g_ret
            assign src = retire_i;
        end else begin : g_evt
            assign src = event_i[k];
        end
        assign inc[k]     = src & ~inhibit_q[OFF];
        assign cnt_ext[k] = 64'(cnt[k]);

        csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .inc_i   (inc[k]),
            .wr_lo_i (wr_lo[k]),
            .wr_hi_i (wr_hi[k]),
            .wdata_i (wr_val),
            .cnt_o   (cnt[k]),
            .wrap_o  (wrap[k])
        );
    end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank (NUM_CNT=4, CNT_WIDTH=40): hand sequences plus vector tables.
module tb_csr_counter_bank;
    import csr_cnt_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       retire;
    logic [3:0] ev;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    csr_counter_bank_if #(.DATA_WIDTH(32)) bus ();

    csr_counter_bank #(.NUM_CNT(4), .CNT_WIDTH(40), .DATA_WIDTH(32)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .retire_i  (retire),
        .event_i   (ev),
        .csr       (bus),
        .ovf_irq_o (irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        csr_op_e     op;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic        exp_ill;
    } rvec_t;

    typedef struct {
        logic [11:0] addr;
        csr_op_e     op;
        logic [31:0] wdata;
        logic [11:0] rd_addr;
        logic [31:0] exp;
    } wvec_t;

    rvec_t rv[19];
    wvec_t wv[8];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [11:0] a, input csr_op_e op, input logic [31:0] wd);
        bus.csr_addr_i  = a;
        bus.csr_op_i    = op;
        bus.csr_wdata_i = wd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string name);
        drive(a, CSR_OP_READ, 32'h0);
        #1;
        chk(name, bus.csr_rdata_o, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input csr_op_e op, input logic [31:0] wd);
        drive(a, op, wd);
        step();
        drive(a, CSR_OP_READ, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // State when tables run: cnt0=AB_12345678, cnt1=4, cnt2=0, cnt3=FF_00000007,
        // inhibit=0x1D, ovf status 0, mask 1.
        rv[0]  = '{12'hC00, CSR_OP_READ,  32'h0,      32'h12345678, 1'b1, 1'b0};
        rv[1]  = '{12'hC80, CSR_OP_READ,  32'h0,      32'h000000AB, 1'b1, 1'b0};
        rv[2]  = '{12'hB00, CSR_OP_READ,  32'h0,      32'h12345678, 1'b1, 1'b0};
        rv[3]  = '{12'hB80, CSR_OP_READ,  32'h0,      32'h000000AB, 1'b1, 1'b0};
        rv[4]  = '{12'hC02, CSR_OP_READ,  32'h0,      32'h00000004, 1'b1, 1'b0};
        rv[5]  = '{12'hC03, CSR_OP_READ,  32'h0,      32'h00000000, 1'b1, 1'b0};
        rv[6]  = '{12'hC04, CSR_OP_READ,  32'h0,      32'h00000007, 1'b1, 1'b0};
        rv[7]  = '{12'hC84, CSR_OP_READ,  32'h0,      32'h000000FF, 1'b1, 1'b0};
        rv[8]  = '{12'hB84, CSR_OP_READ,  32'h0,      32'h000000FF, 1'b1, 1'b0};
        rv[9]  = '{12'h320, CSR_OP_READ,  32'h0,      32'h0000001D, 1'b1, 1'b0};
        rv[10] = '{12'h7C0, CSR_OP_READ,  32'h0,      32'h00000000, 1'b1, 1'b0};
        rv[11] = '{12'h7C1, CSR_OP_READ,  32'h0,      32'h00000001, 1'b1, 1'b0};
        rv[12] = '{12'hC05, CSR_OP_READ,  32'h0,      32'h00000000, 1'b0, 1'b0};
        rv[13] = '{12'hC01, CSR_OP_READ,  32'h0,      32'h00000000, 1'b0, 1'b0};
        rv[14] = '{12'hC00, CSR_OP_SET,   32'hFFFF,   32'h12345678, 1'b1, 1'b1};
        rv[15] = '{12'hC80, CSR_OP_CLEAR, 32'hFFFF,   32'h000000AB, 1'b1, 1'b1};
        rv[16] = '{12'hB00, CSR_OP_WRITE, 32'h0,      32'h12345678, 1'b1, 1'b0};
        rv[17] = '{12'h123, CSR_OP_WRITE, 32'hFFFF,   32'h00000000, 1'b0, 1'b0};
        rv[18] = '{12'h7C2, CSR_OP_READ,  32'h0,      32'h00000000, 1'b0, 1'b0};

        wv[0] = '{12'hB80, CSR_OP_SET,   32'h00000100, 12'hC80, 32'h000000AB};
        wv[1] = '{12'hB00, CSR_OP_CLEAR, 32'h0000FFFF, 12'hC00, 32'h12340000};
        wv[2] = '{12'hB00, CSR_OP_SET,   32'h0000000F, 12'hC00, 32'h1234000F};
        wv[3] = '{12'hB80, CSR_OP_WRITE, 32'hFFFFFF01, 12'hC80, 32'h00000001};
        wv[4] = '{12'h7C1, CSR_OP_CLEAR, 32'h00000001, 12'h7C1, 32'h00000000};
        wv[5] = '{12'h7C1, CSR_OP_SET,   32'hFFFFFFFF, 12'h7C1, 32'h0000001D};
        wv[6] = '{12'h7C0, CSR_OP_CLEAR, 32'hFFFFFFFF, 12'h7C0, 32'h00000000};
        wv[7] = '{12'h320, CSR_OP_CLEAR, 32'h0000001C, 12'h320, 32'h00000001};

        rst_n  = 1'b0;
        retire = 1'b0;
        ev     = 4'h0;
        drive(12'hC00, CSR_OP_READ, 32'h0);
        #1;
        rd(12'hC00, 32'h0, "reset cycle");
        rd(12'h7C0, 32'h0, "reset ovf");
        rd(12'h320, 32'h0, "reset inhibit");
        chk("reset irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // Ten idle cycles.
        repeat (10) step();
        rd(12'hC00, 32'd10, "idle cycle");
        rd(12'hC02, 32'd0,  "idle instret");
        rd(12'hC80, 32'd0,  "idle cycle hi");

        // Wrap of the cycle counter with overflow irq.
        csr_wr(12'h7C1, CSR_OP_WRITE, 32'h1);
        csr_wr(12'hB00, CSR_OP_WRITE, 32'hFFFFFFFF);
        csr_wr(12'hB80, CSR_OP_WRITE, 32'hFFFFFFFF);
        rd(12'hC00, 32'hFFFFFFFF, "allones lo");
        rd(12'hC80, 32'h000000FF, "allones hi dropped");
        rd(12'h7C0, 32'h0, "write no ovf");
        chk("irq before wrap", 32'(irq), 32'h0);
        step();
        rd(12'hC00, 32'h0, "wrap lo");
        rd(12'h7C0, 32'h1, "wrap ovf");
        chk("irq after wrap", 32'(irq), 32'h1);
        csr_wr(12'h7C0, CSR_OP_WRITE, 32'h1);
        chk("irq cleared", 32'(irq), 32'h0);
        rd(12'h7C0, 32'h0, "ovf cleared");

        // Overflow set coinciding with a status clear; op 3 has no effect.
        csr_wr(12'hB00, CSR_OP_WRITE, 32'hFFFFFFFF);
        csr_wr(12'hB80, CSR_OP_WRITE, 32'hFFFFFFFF);
        csr_wr(12'h7C0, CSR_OP_SET, 32'h1);
        rd(12'h7C0, 32'h1, "set wins");
        chk("irq set wins", 32'(irq), 32'h1);
        csr_wr(12'h7C0, CSR_OP_CLEAR, 32'h1);
        rd(12'h7C0, 32'h1, "ovf op3 noop");
        csr_wr(12'h7C0, CSR_OP_SET, 32'h1);
        rd(12'h7C0, 32'h0, "ovf op2 clear");

        // Instret inhibit.
        csr_wr(12'h320, CSR_OP_WRITE, 32'h4);
        retire = 1'b1;
        repeat (5) step();
        retire = 1'b0;
        rd(12'hC02, 32'd0, "instret inhibited");
        rd(12'h320, 32'h4, "inhibit rd");
        csr_wr(12'h320, CSR_OP_WRITE, 32'h0);
        retire = 1'b1;
        repeat (3) step();
        retire = 1'b0;
        rd(12'hC02, 32'd3, "instret 3");

        // Inhibit write cycle still uses the old inhibit.
        retire = 1'b1;
        drive(12'h320, CSR_OP_WRITE, 32'h4);
        step();
        drive(12'h320, CSR_OP_READ, 32'h0);
        step();
        retire = 1'b0;
        rd(12'hC02, 32'd4, "inhibit next cycle");
        csr_wr(12'h320, CSR_OP_WRITE, 32'h0);

        // Write beats increment.
        csr_wr(12'hB00, CSR_OP_WRITE, 32'h10);
        rd(12'hC00, 32'h10, "write no inc");
        step();
        rd(12'hC00, 32'h11, "inc after write");

        // Illegal and unmapped.
        drive(12'hC02, CSR_OP_WRITE, 32'h55);
        #1;
        chk("ro illegal", 32'(bus.csr_illegal_o), 32'h1);
        chk("ro hit", 32'(bus.csr_hit_o), 32'h1);
        step();
        rd(12'hC02, 32'd4, "ro unaffected");
        drive(12'h123, CSR_OP_WRITE, 32'hFFFF);
        #1;
        chk("unmapped hit", 32'(bus.csr_hit_o), 32'h0);
        chk("unmapped rdata", bus.csr_rdata_o, 32'h0);
        drive(12'hC00, CSR_OP_READ, 32'h0);

        // hpm event counter; event bits 0..1 are ignored.
        for (int i = 0; i < 7; i++) begin
            ev = 4'b1011;
            step();
            ev = 4'h0;
            step();
        end
        rd(12'hC04, 32'd7, "hpm3 count");
        rd(12'hC03, 32'd0, "hpm2 idle");
        rd(12'hC02, 32'd4, "instret ignores ev");
        csr_wr(12'hB84, CSR_OP_WRITE, 32'hFFFFFFFF);
        rd(12'hC84, 32'h000000FF, "hpm3 hi 40b");
        rd(12'hC04, 32'd7, "hpm3 lo kept");

        // Freeze all counters for the tables.
        csr_wr(12'h320, CSR_OP_WRITE, 32'hFFFFFFFF);
        rd(12'h320, 32'h1D, "inhibit mask");
        csr_wr(12'hB00, CSR_OP_WRITE, 32'h12345678);
        csr_wr(12'hB80, CSR_OP_WRITE, 32'hAB);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(rv[i].addr, rv[i].op, rv[i].wdata);
            #1;
            chk($sformatf("rv%0d rdata", i), bus.csr_rdata_o, rv[i].exp_rdata);
            chk($sformatf("rv%0d hit", i), 32'(bus.csr_hit_o), 32'(rv[i].exp_hit));
            chk($sformatf("rv%0d illegal", i), 32'(bus.csr_illegal_o), 32'(rv[i].exp_ill));
            drive(rv[i].addr, CSR_OP_READ, 32'h0);
        end

        step();
        for (int i = 0; i < 8; i++) begin
            csr_wr(wv[i].addr, wv[i].op, wv[i].wdata);
            rd(wv[i].rd_addr, wv[i].exp, $sformatf("wv%0d", i));
        end

        // Reset in the middle of a pending write.
        drive(12'hB00, CSR_OP_WRITE, 32'h999);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst irq", 32'(irq), 32'h0);
        rd(12'hC00, 32'h0, "rst cycle");
        rd(12'h7C1, 32'h0, "rst mask");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rd(12'hC00, 32'h1, "first inc after rst");
        rd(12'h320, 32'h0, "rst inhibit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
